// File: rtl/memmap_pkg.sv
// Shared types and defaults for the CPU memory-map router and its address decoder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package memmap_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int ERR_CNT_WIDTH  = 16;

  // Router transaction phases; one transaction is in flight at a time.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

endpackage

// File: rtl/memmap_decoder.sv
// Priority base/mask region decoder: returns hit, region index and offset within the region.
// Latency: purely combinational, zero cycles.
// Backpressure: none; shared with the instruction-fetch path, so it has no state.
module memmap_decoder
  import memmap_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'hFFFF0000, 32'h00000000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hFFFF0000, 32'hFFFFC000},
  parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic [IDX_W-1:0]      o_idx,
  output logic [ADDR_WIDTH-1:0] o_offset
);

  // Scan from the highest index down so the lowest matching region is the one left standing.
  always_comb begin
    o_hit    = 1'b0;
    o_idx    = '0;
    o_offset = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((i_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        o_hit    = 1'b1;
        o_idx    = IDX_W'(i);
        o_offset = i_addr & ~REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: rtl/memmap_router.sv
// Routes one CPU load/store to a base/mask-selected target; unmapped or timed-out accesses return err.
// Latency: unmapped 1 cycle, zero-wait write 2 cycles, zero-wait read 3 cycles after acceptance.
// Backpressure: single outstanding transaction; o_req_ready only in IDLE, response held until i_rsp_ready.
module memmap_router
  import memmap_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_REGIONS    = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'hFFFF0000, 32'h00000000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hFFFF0000, 32'hFFFFC000},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [ADDR_WIDTH-1:0]             i_req_addr,
  input  logic [DATA_WIDTH-1:0]             i_req_data,
  input  logic [DATA_WIDTH/8-1:0]           i_req_bwe,
  input  logic                              i_req_we,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  output logic [DATA_WIDTH-1:0]             o_rsp_data,
  output logic                              o_rsp_err,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [ADDR_WIDTH-1:0]             o_tgt_addr,
  output logic [DATA_WIDTH-1:0]             o_tgt_data,
  output logic [DATA_WIDTH/8-1:0]           o_tgt_bwe,
  output logic                              o_tgt_we,
  output logic [NUM_REGIONS-1:0]            o_tgt_req_valid,
  input  logic [NUM_REGIONS-1:0]            i_tgt_req_ready,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] i_tgt_rsp_data,
  input  logic [NUM_REGIONS-1:0]            i_tgt_rsp_valid,
  output logic [NUM_REGIONS-1:0]            o_tgt_rsp_ready,
  output logic [ERR_CNT_WIDTH-1:0]          o_err_count
);

  localparam int BW    = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Latched request; the target sees these fields unchanged for the whole transaction.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] off;
    logic [DATA_WIDTH-1:0] dat;
    logic [BW-1:0]         bwe;
    logic                  we;
    logic [IDX_W-1:0]      idx;
  } req_t;

  logic                     dec_hit;
  logic [IDX_W-1:0]         dec_idx;
  logic [ADDR_WIDTH-1:0]    dec_off;

  state_e                   state_q, state_d;
  req_t                     req_q, req_d;
  logic [TO_W-1:0]          tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [NUM_REGIONS-1:0]   sel_oh;
  logic                     sel_req_rdy;
  logic                     sel_rsp_vld;
  logic [DATA_WIDTH-1:0]    sel_rsp_dat;
  logic                     err_enter;
  logic                     tmo_last;

  memmap_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .i_addr   (i_req_addr),
    .o_hit    (dec_hit),
    .o_idx    (dec_idx),
    .o_offset (dec_off)
  );

  // Turn the latched index into a one-hot select and pick out only that target's inputs.
  always_comb begin
    sel_oh      = '0;
    sel_req_rdy = 1'b0;
    sel_rsp_vld = 1'b0;
    sel_rsp_dat = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (req_q.idx == IDX_W'(i)) begin
        sel_oh[i]   = 1'b1;
        sel_req_rdy = i_tgt_req_ready[i];
        sel_rsp_vld = i_tgt_rsp_valid[i];
        sel_rsp_dat = i_tgt_rsp_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign tmo_last = (tmo_q == TO_LAST);

  // Transaction sequencing; a handshake on the terminal timeout cycle takes priority over the timeout.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    tmo_d      = tmo_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    err_enter  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          req_d.off = dec_off;
          req_d.dat = i_req_data;
          req_d.bwe = i_req_bwe;
          req_d.we  = i_req_we;
          req_d.idx = dec_idx;
          tmo_d     = '0;
          if (dec_hit) begin
            state_d = ST_DISPATCH;
          end else begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            err_enter  = 1'b1;
          end
        end
      end
      ST_DISPATCH: begin
        tmo_d = tmo_q + 1'b1;
        if (sel_req_rdy) begin
          if (req_q.we) begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b0;
            rsp_data_d = '0;
          end else begin
            state_d = ST_WAIT_RSP;
            tmo_d   = '0;
          end
        end else if (tmo_last) begin
          state_d    = ST_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          err_enter  = 1'b1;
        end
      end
      ST_WAIT_RSP: begin
        tmo_d = tmo_q + 1'b1;
        if (sel_rsp_vld) begin
          state_d    = ST_RESP;
          rsp_err_d  = 1'b0;
          rsp_data_d = sel_rsp_dat;
        end else if (tmo_last) begin
          state_d    = ST_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          err_enter  = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating count of error responses, bumped once per entry into an error response.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_enter && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      tmo_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      tmo_q      <= tmo_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Ready is gated by reset so the CPU never sees the block accepting while it is held in reset.
  assign o_req_ready     = i_rst && (state_q == ST_IDLE);
  assign o_rsp_valid     = (state_q == ST_RESP);
  assign o_rsp_data      = rsp_data_q;
  assign o_rsp_err       = rsp_err_q;
  assign o_tgt_addr      = req_q.off;
  assign o_tgt_data      = req_q.dat;
  assign o_tgt_bwe       = req_q.bwe;
  assign o_tgt_we        = req_q.we;
  assign o_tgt_req_valid = (state_q == ST_DISPATCH) ? sel_oh : '0;
  assign o_tgt_rsp_ready = (state_q == ST_WAIT_RSP) ? sel_oh : '0;
  assign o_err_count     = err_cnt_q;

endmodule

// File: tb/tb_memmap_router.sv
// Directed and randomized transactions against a timing/decode model of the router.
// Latency: n/a.
// Backpressure: n/a.
module tb_memmap_router;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 2;
  localparam int T  = 8;
  localparam logic [NR*AW-1:0] RB = {32'hFFFF0000, 32'h00000000};
  localparam logic [NR*AW-1:0] RM = {32'hFFFF0000, 32'hFFFFC000};

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [AW-1:0]  i_req_addr;
  logic [DW-1:0]  i_req_data;
  logic [3:0]     i_req_bwe;
  logic           i_req_we;
  logic           i_req_valid;
  logic           o_req_ready;
  logic [DW-1:0]  o_rsp_data;
  logic           o_rsp_err;
  logic           o_rsp_valid;
  logic           i_rsp_ready;
  logic [AW-1:0]  o_tgt_addr;
  logic [DW-1:0]  o_tgt_data;
  logic [3:0]     o_tgt_bwe;
  logic           o_tgt_we;
  logic [NR-1:0]  o_tgt_req_valid;
  logic [NR-1:0]  i_tgt_req_ready;
  logic [NR*DW-1:0] i_tgt_rsp_data;
  logic [NR-1:0]  i_tgt_rsp_valid;
  logic [NR-1:0]  o_tgt_rsp_ready;
  logic [15:0]    o_err_count;

  memmap_router #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUM_REGIONS    (NR),
    .REGION_BASE    (RB),
    .REGION_MASK    (RM),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_addr      (i_req_addr),
    .i_req_data      (i_req_data),
    .i_req_bwe       (i_req_bwe),
    .i_req_we        (i_req_we),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .o_rsp_data      (o_rsp_data),
    .o_rsp_err       (o_rsp_err),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_tgt_addr      (o_tgt_addr),
    .o_tgt_data      (o_tgt_data),
    .o_tgt_bwe       (o_tgt_bwe),
    .o_tgt_we        (o_tgt_we),
    .o_tgt_req_valid (o_tgt_req_valid),
    .i_tgt_req_ready (i_tgt_req_ready),
    .i_tgt_rsp_data  (i_tgt_rsp_data),
    .i_tgt_rsp_valid (i_tgt_rsp_valid),
    .o_tgt_rsp_ready (o_tgt_rsp_ready),
    .o_err_count     (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  // Memory map as a plain table: region 0 = 16 KiB at 0, region 1 = 64 KiB at 0xFFFF0000.
  logic [31:0] base_a [NR] = '{32'h00000000, 32'hFFFF0000};
  logic [31:0] mask_a [NR] = '{32'hFFFFC000, 32'hFFFF0000};

  int n_cmp = 0;
  int n_bad = 0;
  int model_errs = 0;

  task automatic chk(input string nm, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", nm, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic void ref_decode(input logic [31:0] a, output bit hit, output int idx, output logic [31:0] off);
    hit = 1'b0;
    idx = 0;
    off = '0;
    for (int i = 0; i < NR; i++) begin
      if (!hit && ((a & mask_a[i]) == base_a[i])) begin
        hit = 1'b1;
        idx = i;
        off = a & ~mask_a[i];
      end
    end
  endfunction

  // Random noise on every target; the selected one (if any) gets the scripted ready/valid/data.
  task automatic drive_tgts(input bit hit, input int idx, input bit rq, input bit rv, input logic [31:0] rd);
    i_tgt_req_ready = NR'($urandom);
    i_tgt_rsp_valid = NR'($urandom);
    for (int i = 0; i < NR; i++) i_tgt_rsp_data[i*DW +: DW] = $urandom;
    if (hit) begin
      i_tgt_req_ready[idx] = rq;
      i_tgt_rsp_valid[idx] = rv;
      i_tgt_rsp_data[idx*DW +: DW] = rv ? rd : 32'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, "ctl_outputs", {o_req_ready, o_rsp_valid, o_rsp_err, o_tgt_we, o_tgt_req_valid, o_tgt_rsp_ready, o_tgt_bwe, o_err_count}, 64'd0);
    chk(nm, "rsp_data_tgt_addr", {o_rsp_data, o_tgt_addr}, 64'd0);
    chk(nm, "tgt_data", o_tgt_data, 64'd0);
  endtask

  // One CPU transaction: w = target request-ready delay, r = target response delay, hold = RESP stall cycles.
  task automatic run_txn(input string nm, input logic [31:0] a, input bit we, input logic [31:0] d,
                         input logic [3:0] be, input int w, input int r, input logic [31:0] rd, input int hold);
    bit hit;
    int idx;
    logic [31:0] off;
    int lat, req_last, rsp_first, rsp_last, nreq, nrsp;
    bit exp_err, rq, rv;
    logic [31:0] exp_dat;
    logic [NR-1:0] oh, exp_rv, exp_rr;

    ref_decode(a, hit, idx, off);
    oh = '0;
    if (hit) oh[idx] = 1'b1;
    req_last = 0; rsp_first = 1; rsp_last = 0; nreq = 0; nrsp = 0;
    exp_err = 1'b1; exp_dat = '0;
    if (!hit) begin
      lat = 1;
    end else if (w >= T) begin
      lat = T + 1; req_last = T;
    end else if (we) begin
      lat = w + 2; req_last = w + 1; exp_err = 1'b0;
    end else begin
      req_last = w + 1; rsp_first = w + 2;
      if (r >= T) begin
        lat = w + T + 2; rsp_last = w + T + 1;
      end else begin
        lat = w + r + 3; rsp_last = w + r + 2; exp_err = 1'b0; exp_dat = rd;
      end
    end

    chk(nm, "req_ready_idle", o_req_ready, 1);
    i_req_addr = a; i_req_data = d; i_req_bwe = be; i_req_we = we; i_req_valid = 1'b1;
    drive_tgts(1'b0, 0, 1'b0, 1'b0, '0);
    i_rsp_ready = 1'($urandom);
    tick();
    i_req_valid = 1'b0;
    i_req_addr = $urandom; i_req_data = $urandom; i_req_bwe = 4'($urandom); i_req_we = 1'($urandom);

    for (int c = 1; c <= lat; c++) begin
      exp_rv = (c <= req_last) ? oh : '0;
      exp_rr = (c >= rsp_first && c <= rsp_last) ? oh : '0;
      chk(nm, "rsp_valid_timing", o_rsp_valid, (c == lat));
      chk(nm, "req_ready_busy", o_req_ready, 0);
      chk(nm, "tgt_req_valid", o_tgt_req_valid, exp_rv);
      chk(nm, "tgt_rsp_ready", o_tgt_rsp_ready, exp_rr);
      if (exp_rv != '0) begin
        chk(nm, "tgt_addr", o_tgt_addr, off);
        chk(nm, "tgt_data", o_tgt_data, d);
        chk(nm, "tgt_bwe", o_tgt_bwe, be);
        chk(nm, "tgt_we", o_tgt_we, we);
      end
      if (c < lat) begin
        rq = 1'b0; rv = 1'b0;
        if (hit && o_tgt_req_valid[idx]) begin nreq++; rq = (nreq > w); end
        if (hit && o_tgt_rsp_ready[idx]) begin nrsp++; rv = (nrsp > r); end
        drive_tgts(hit, idx, rq, rv, rd);
        i_rsp_ready = 1'($urandom);
        tick();
      end
    end

    chk(nm, "rsp_err", o_rsp_err, exp_err);
    chk(nm, "rsp_data", o_rsp_data, exp_dat);
    if (exp_err && model_errs < 65535) model_errs++;
    chk(nm, "err_count", o_err_count, model_errs);
    drive_tgts(1'b0, 0, 1'b0, 1'b0, '0);

    for (int h = 0; h < hold; h++) begin
      i_rsp_ready = 1'b0;
      tick();
      chk(nm, "hold_rsp_valid", o_rsp_valid, 1);
      chk(nm, "hold_rsp_err", o_rsp_err, exp_err);
      chk(nm, "hold_rsp_data", o_rsp_data, exp_dat);
      chk(nm, "hold_req_ready", o_req_ready, 0);
    end
    i_rsp_ready = 1'b1;
    tick();
    chk(nm, "rsp_valid_after_ack", o_rsp_valid, 0);
    chk(nm, "req_ready_after_ack", o_req_ready, 1);

    // If the DUT went astray, coax it back to IDLE within a bounded number of cycles.
    for (int g = 0; g < 600 && !o_req_ready; g++) begin
      i_tgt_req_ready = '1; i_tgt_rsp_valid = '1; i_rsp_ready = 1'b1;
      tick();
    end
    i_rsp_ready = 1'b0;
    i_tgt_req_ready = '0; i_tgt_rsp_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, rd;
    int sel, w, r, hold;
    bit we;

    i_rst = 1'b0;
    i_req_addr = '0; i_req_data = '0; i_req_bwe = '0; i_req_we = 1'b0; i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    i_tgt_req_ready = '0; i_tgt_rsp_valid = '0; i_tgt_rsp_data = '0;
    #3;
    chk_reset_outputs("reset_t0");
    tick();
    chk_reset_outputs("reset_edge");
    i_rst = 1'b1;
    tick();

    run_txn("rd_bram",     32'h00000010, 1'b0, 32'h0,        4'h0,    0, 0, 32'h12345678, 0);
    run_txn("wr_mmio",     32'hFFFF0004, 1'b1, 32'hCAFEBABE, 4'b0011, 0, 0, 32'h0,        0);
    run_txn("rd_unmapped", 32'h00010000, 1'b0, 32'h0,        4'h0,    0, 0, 32'h0,        0);
    run_txn("wr_timeout",  32'hFFFF0008, 1'b1, 32'h11112222, 4'hF,  100, 0, 32'h0,        0);
    run_txn("rd_hold5",    32'h00003FFC, 1'b0, 32'h0,        4'h0,    1, 2, 32'hDEADBEEF, 5);
    run_txn("wr_edge_hs",  32'hFFFF0010, 1'b1, 32'h0BADF00D, 4'b1000, T-1, 0, 32'h0,      1);
    run_txn("rd_edge_hs",  32'h00000100, 1'b0, 32'h0,        4'h0,    0, T-1, 32'h87654321, 0);
    run_txn("rd_rsp_tmo",  32'hFFFF00F0, 1'b0, 32'h0,        4'h0,    2, T, 32'h55AA55AA, 2);

    // Reset while a read is parked in WAIT_RSP.
    i_req_addr = 32'h00000020; i_req_we = 1'b0; i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    i_tgt_req_ready = 2'b01;
    tick();
    i_tgt_req_ready = '0;
    chk("rst_mid", "wait_rsp_ready", o_tgt_rsp_ready, 2'b01);
    #2 i_rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_errs = 0;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    run_txn("rd_after_rst", 32'h00000000, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA5A50001, 0);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    a = $urandom & 32'h00003FFF;
        2:       a = 32'hFFFF0000 | ($urandom & 32'h0000FFFF);
        default: a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
      endcase
      we   = 1'($urandom);
      d    = $urandom;
      rd   = $urandom;
      w    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 1);
      r    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 1);
      hold = $urandom_range(0, 3);
      run_txn("random", a, we, d, 4'($urandom), w, r, rd, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memmap_router.md
Name: memmap_router

Overview:
Parametrised successor to the single-BRAM/MMIO memory map. It routes one CPU load/store at a time to one of NUM_REGIONS targets, selected by base/mask match. Each target has valid/ready request and response handshakes. Unmapped accesses and target timeouts return an error response instead of hanging the CPU. The block sits between the CPU load/store unit and the BRAM, MMIO and peripheral targets.

Parameters:
DATA_WIDTH, 32, data bus width; bytemask width is DATA_WIDTH/8
ADDR_WIDTH, 32, address width
NUM_REGIONS, 2, number of targets (1..8)
REGION_BASE, {32'hFFFF0000, 32'h00000000}, packed NUM_REGIONS*ADDR_WIDTH; region i occupies slice i
REGION_MASK, {32'hFFFF0000, 32'hFFFFC000}, packed; region i matches when (addr & MASK[i]) == BASE[i]
TIMEOUT_CYCLES, 256, cycles allowed per target phase before an error response; minimum 2

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_req_addr  in  ADDR_WIDTH  CPU byte address
i_req_data  in  DATA_WIDTH  write data
i_req_bwe  in  DATA_WIDTH/8  write bytemask
i_req_we  in  1  1=write, 0=read
i_req_valid  in  1  CPU request valid
o_req_ready  out  1  router accepts a request
o_rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors
o_rsp_err  out  1  unmapped address or timeout
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  CPU accepts the response
o_tgt_addr  out  ADDR_WIDTH  offset within region: addr & ~MASK[idx]; shared by all targets
o_tgt_data  out  DATA_WIDTH  shared write data
o_tgt_bwe  out  DATA_WIDTH/8  shared bytemask
o_tgt_we  out  1  shared write flag
o_tgt_req_valid  out  NUM_REGIONS  one-hot request valid
i_tgt_req_ready  in  NUM_REGIONS  per-target request ready
i_tgt_rsp_data  in  NUM_REGIONS*DATA_WIDTH  per-target read data
i_tgt_rsp_valid  in  NUM_REGIONS  per-target response valid
o_tgt_rsp_ready  out  NUM_REGIONS  one-hot response ready
o_err_count  out  16  saturating count of error responses

Behaviour:
- While i_rst is low: state is IDLE and every output is 0, including o_req_ready. Reset mid-transaction abandons the transaction. Targets must tolerate a dropped valid.
- States and transitions:
  - IDLE: o_req_ready=1. On i_req_valid, latch addr/data/bwe/we plus decode result (hit, idx). Hit -> DISPATCH; miss -> RESP with err=1.
  - DISPATCH: o_tgt_req_valid[idx]=1; o_tgt_* driven from the latched request and held stable. On i_tgt_req_ready[idx]: write -> RESP, err=0, data=0; read -> WAIT_RSP.
  - WAIT_RSP: o_tgt_rsp_ready[idx]=1. On i_tgt_rsp_valid[idx], capture that target's data slice -> RESP, err=0.
  - RESP: o_rsp_valid=1 with data/err held stable. On i_rsp_ready -> IDLE. The next request is accepted no earlier than the following cycle.
- Decode: lowest index wins when regions overlap. Non-selected targets see valid/ready = 0. Inputs from non-selected targets are ignored.
- Timeout:
  - Counter clears on entry to DISPATCH and to WAIT_RSP, and increments every cycle in those states.
  - At count == TIMEOUT_CYCLES-1 with no handshake -> RESP with err=1, data=0. The target valid/ready drops that same transition.
  - If the handshake and the terminal count coincide, the handshake wins.
- o_err_count increments by one on each entry into RESP with err=1 and saturates at 16'hFFFF.
- Latency:
  - Unmapped access: response valid 1 cycle after acceptance.
  - Zero-wait write: 2 cycles after acceptance.
  - Zero-wait read: 3 cycles after acceptance.
- Only one transaction is outstanding. o_req_ready=0 in every state except IDLE.

Decomposition:
- memmap_pkg holds:
  - state enum (IDLE, DISPATCH, WAIT_RSP, RESP)
  - DATA_WIDTH/ADDR_WIDTH defaults
  - ERR_CNT_WIDTH=16
- Sub-module memmap_decoder: purely combinational priority base/mask match. Outputs hit, idx[$clog2(NUM_REGIONS)] and the region offset. It is reused by the instruction-fetch path.

Test Plan:
- Read 0x00000010; target0 holds req_ready=1 and returns 32'h12345678 one cycle later -> o_tgt_addr=0x10, o_rsp_data=0x12345678, err=0, rsp_valid 3 cycles after acceptance.
- Write 0xFFFF0004, data 0xCAFEBABE, bwe 4'b0011 -> only o_tgt_req_valid[1]=1, o_tgt_addr=0x4, bwe 4'b0011 passed through, response err=0 and data=0.
- Read 0x00010000 (unmapped) -> no target valid asserted, err=1 one cycle after acceptance, o_err_count=1.
- Target1 never asserts req_ready, TIMEOUT_CYCLES=8 -> err=1 after 8 DISPATCH cycles, o_tgt_req_valid drops, router returns to IDLE.
- Hold i_rsp_ready=0 for 5 cycles in RESP -> data/err stable and o_req_ready=0 throughout; accepted on cycle 6.
- Assert reset low in WAIT_RSP -> all outputs 0 asynchronously; after release a fresh read to 0x0 completes normally.
